// File: rtl/mu0_mem_pkg.sv
// Shared types and defaults for the MU0 memory arbiter.
// Owner and FSM state encodings live here so every file agrees on them.
package mu0_mem_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   typedef enum logic {
      OWN_CPU  = 1'b0,
      OWN_HOST = 1'b1
   } owner_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      ACK   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mu0_rr_pick2.sv
// Combinational two-way round-robin picker: req[0]=CPU, req[1]=host.
// lock masks the CPU so only the host can win.
module mu0_rr_pick2
   import mu0_mem_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     last_owner,
   input  logic       lock,
   output owner_t     winner,
   output logic       valid,
   output logic       conflict
);

   logic [1:0] req_eff;

   // Mask the CPU under lock, then pick a lone requester or alternate on a tie.
   always_comb begin
      req_eff = req;
      if (lock) req_eff[0] = 1'b0;
      valid    = |req_eff;
      conflict = &req_eff;
      winner   = OWN_CPU;
      unique case (req_eff)
         2'b01:   winner = OWN_CPU;
         2'b10:   winner = OWN_HOST;
         2'b11:   winner = (last_owner == OWN_HOST) ? OWN_CPU : OWN_HOST;
         default: winner = OWN_CPU;
      endcase
   end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Registered round-robin arbiter sharing the MU0 memory between core and host.
// Optional host lock is built in when MU0_ARB_HOST_LOCK_EN is defined.
module mu0_mem_arbiter
   import mu0_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_rnw,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              host_req,
   input  logic              host_rnw,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
`ifdef MU0_ARB_HOST_LOCK_EN
   input  logic              host_lock,
`endif
   output logic              host_gnt,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_rq,
   output logic              mem_rnw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  conflict_cnt
);

   arb_state_t        state;
   owner_t            last_owner;
   owner_t            owner;
   owner_t            winner;
   logic              valid;
   logic              conflict;
   logic              lock_eff;
   logic              sel_rnw;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

`ifdef MU0_ARB_HOST_LOCK_EN
   logic lock_flag;

   assign lock_eff = lock_flag & host_lock;

   // Lock is taken by a locked host grant and released at the first unlocked IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_flag <= 1'b0;
      end else if (state == IDLE) begin
         if (!host_lock)
            lock_flag <= 1'b0;
         else if (valid && winner == OWN_HOST)
            lock_flag <= 1'b1;
      end
   end
`else
   assign lock_eff = 1'b0;
`endif

   mu0_rr_pick2 u_pick (
      .req        ({host_req, cpu_req}),
      .last_owner (last_owner),
      .lock       (lock_eff),
      .winner     (winner),
      .valid      (valid),
      .conflict   (conflict)
   );

   // Route the winning requester's command toward the memory latch.
   always_comb begin
      sel_rnw   = cpu_rnw;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      if (winner == OWN_HOST) begin
         sel_rnw   = host_rnw;
         sel_addr  = host_addr;
         sel_wdata = host_wdata;
      end
   end

   // Arbitration FSM; every output is a register set on entry to its state.
   // Read data is captured at the close of the strobe cycle so it rides with ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_owner   <= OWN_HOST;
         owner        <= OWN_CPU;
         cpu_gnt      <= 1'b0;
         cpu_ack      <= 1'b0;
         host_gnt     <= 1'b0;
         host_ack     <= 1'b0;
         mem_rq       <= 1'b0;
         mem_rnw      <= 1'b1;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cpu_rdata    <= '0;
         host_rdata   <= '0;
         conflict_cnt <= '0;
      end else begin
         cpu_gnt  <= 1'b0;
         cpu_ack  <= 1'b0;
         host_gnt <= 1'b0;
         host_ack <= 1'b0;
         mem_rq   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (valid) begin
                  owner      <= winner;
                  last_owner <= winner;
                  mem_rq     <= 1'b1;
                  mem_rnw    <= sel_rnw;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  cpu_gnt    <= (winner == OWN_CPU);
                  host_gnt   <= (winner == OWN_HOST);
                  if (conflict && conflict_cnt != '1)
                     conflict_cnt <= conflict_cnt + CNT_W'(1);
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (owner == OWN_CPU) begin
                  cpu_ack <= 1'b1;
                  if (mem_rnw) cpu_rdata <= mem_rdata;
               end else begin
                  host_ack <= 1'b1;
                  if (mem_rnw) host_rdata <= mem_rdata;
               end
               state <= ACK;
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
